mc_updown_counter: RTL and testbench
====================================

# mc_updown_counter

Parametrised, cascadable synchronous up/down counter, successor to the 4-bit MC14516B.
- Generalises width to WIDTH bits.
- Adds optional BCD (decade-per-nibble) counting, a one-shot stop-at-terminal mode and a sticky wrap flag.
- Keeps the MC14516B active-low carry-in/carry-out cascade protocol, so several instances chain into wider counters or timers inside the MC14500B-based system.

## Interface
- WIDTH, default 8: counter width in bits. Must be ≥4 and a multiple of 4.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- preset_enable  in  1  synchronous load of `preset`.
- preset  in  WIDTH  load value.
- up_down  in  1  direction: 1 = up, 0 = down.
- carry_in  in  1  active-low count enable (cascade input).
- one_shot  in  1  1 = stop at terminal value instead of wrapping.
- bcd_mode  in  1  1 = each nibble counts as a decimal digit 0–9. Ignored unless MC_COUNTER_BCD_EN is defined.
- result  out  WIDTH  registered count.
- carry_out  out  1  active-low terminal-count/cascade output.
- wrapped  out  1  sticky flag, set when the counter wraps.

## Operation
- Priority at each rising edge: reset > preset_enable > count.
- Reset: result = 0, wrapped = 0.
- Load: when preset_enable = 1, result ← preset and wrapped ← 0. Loading ignores carry_in and one_shot. Preset is loaded unchecked, even if it holds invalid BCD digits.
- Count: happens only when carry_in = 0 and no hold condition applies. The step is ±1 in the current direction.
- Terminal value (TV):
  - Binary, up: all ones. Binary, down: all zeros.
  - BCD, up: every nibble = 9. BCD, down: all zeros.
- Binary arithmetic is modulo 2^WIDTH: all-ones+1 = 0, 0−1 = all-ones.
- BCD arithmetic:
  - Up: a nibble at 9 goes to 0 and carries into the next nibble.
  - Down: a nibble at 0 goes to 9 and borrows from the next nibble.
  - Up from an invalid digit (10–15): the digit becomes 0 and carries.
  - Down from an invalid digit: the digit decrements in binary (15→14), with no borrow.
  - TV up is reached only through valid digits.
- Wrap: a count taken while result == TV makes result go to 0 (up) or to the all-zero/all-nines/all-ones complement (down), and sets wrapped = 1.
- wrapped stays set until reset or load. A simultaneous wrap and load leaves wrapped = 0, because load wins.
- One-shot: when one_shot = 1 and result == TV for the current direction, the count is suppressed.
  - result holds and wrapped is not set.
  - Changing up_down releases the hold.
- carry_out = 0 iff carry_in = 0 and result == TV for the current direction and mode. Otherwise carry_out = 1.
- carry_out is combinational from result, up_down, bcd_mode and carry_in. This makes a chain of instances (carry_out → next carry_in) behave as a single counter.

## Timing
- Reset values: result = 0, wrapped = 0. carry_out after reset is 0 if carry_in = 0 and up_down = 0, else 1.
- Latency: load and count are visible on result one clock after the sampling edge.
- carry_out and its reflection of up_down / bcd_mode / carry_in changes are combinational, valid in the same cycle, with no extra latency.
- Simultaneous events:
  - Reset together with preset_enable: reset wins.
  - preset_enable together with carry_in = 0: load wins and no count occurs.
- Changing direction while at TV: carry_out re-evaluates immediately. The next count uses the new direction.
- A reset asserted mid-cascade clears only this instance. Downstream instances see carry_out = 1 unless the reset value (0) is TV for a down count.

## Configuration
- MC_COUNTER_BCD_EN defined: BCD logic is compiled in and bcd_mode is honoured.
- MC_COUNTER_BCD_EN undefined: the BCD logic is removed. bcd_mode is ignored and the counter is always binary. The port remains so the interface is identical in both builds.

## Test plan
- WIDTH=8, reset=1 for one edge, then carry_in=1 → result=0x00, wrapped=0, carry_out=1.
- Load preset=0xFE, up, binary, carry_in=0, 2 edges → result 0xFF then 0x00. carry_out=0 while at 0xFF. wrapped=1 after the second edge.
- BCD build, bcd_mode=1, load 0x09, up, 1 edge → 0x10. Load 0x99, up, 1 edge → 0x00 with wrapped=1. Load 0x10, down, 1 edge → 0x09.
- one_shot=1, load 0x01, down, 3 edges → 0x00 and holds, with carry_out=0 and wrapped=0. Then set up_down=1 → carry_out=1, and the next edge gives 0x01.
- Same-edge preset_enable=1 with preset=0x55, carry_in=0 and result at TV → result=0x55, wrapped cleared. Same-edge reset=1 with preset_enable=1 → result=0x00.
- Two instances chained with WIDTH=4 each, binary, up, carry_in=0 on the low instance, from 0x0F → the pair reads 0x10 after one edge. Without MC_COUNTER_BCD_EN, bcd_mode=1 with load 0x09 up gives 0x0A.

Source files
------------

// File: rtl/mc_updown_counter.sv
// Cascadable WIDTH-bit synchronous up/down counter with an MC14516B-style active-low carry cascade.
// Define MC_COUNTER_BCD_EN to compile in decade-per-nibble counting selected by bcd_mode.
module mc_updown_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             preset_enable,
  input  logic [WIDTH-1:0] preset,
  input  logic             up_down,
  input  logic             carry_in,
  input  logic             one_shot,
  input  logic             bcd_mode,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             wrapped
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;
  logic             bcd_en;
  logic [WIDTH-1:0] nines, bcd_inc, bcd_dec;
  logic [WIDTH-1:0] tv, step;
  logic             at_tv, count_en;

`ifdef MC_COUNTER_BCD_EN
  assign bcd_en = bcd_mode;

  // Invalid digits (10-15) clear and carry when counting up, but just decrement without borrow going down.
  always_comb begin
    logic       c, b;
    logic [3:0] nib;
    nines   = '0;
    bcd_inc = '0;
    bcd_dec = '0;
    c = 1'b1;
    b = 1'b1;
    for (int unsigned n = 0; n < NIB; n++) begin
      nines[4*n +: 4] = 4'd9;
      nib = result_q[4*n +: 4];
      if (!c) begin
        bcd_inc[4*n +: 4] = nib;
      end else if (nib >= 4'd9) begin
        bcd_inc[4*n +: 4] = 4'd0;
      end else begin
        bcd_inc[4*n +: 4] = nib + 4'd1;
        c = 1'b0;
      end
      if (!b) begin
        bcd_dec[4*n +: 4] = nib;
      end else if (nib == 4'd0) begin
        bcd_dec[4*n +: 4] = 4'd9;
      end else begin
        bcd_dec[4*n +: 4] = nib - 4'd1;
        b = 1'b0;
      end
    end
  end
`else
  logic unused_bcd_mode;
  assign unused_bcd_mode = bcd_mode;
  assign bcd_en  = 1'b0;
  assign nines   = '0;
  assign bcd_inc = '0;
  assign bcd_dec = '0;
`endif

  assign tv       = up_down ? (bcd_en ? nines : '1) : '0;
  assign at_tv    = (result_q == tv);
  assign count_en = ~carry_in & ~(one_shot & at_tv);

  // Normal step arithmetic already lands on the wrap value when leaving TV.
  assign step = up_down ? (bcd_en ? bcd_inc : result_q + ONE)
                        : (bcd_en ? bcd_dec : result_q - ONE);

  always_comb begin
    result_d  = result_q;
    wrapped_d = wrapped_q;
    if (preset_enable) begin
      result_d  = preset;
      wrapped_d = 1'b0;
    end else if (count_en) begin
      result_d = step;
      if (at_tv) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign result    = result_q;
  assign wrapped   = wrapped_q;
  assign carry_out = ~(~carry_in & at_tv);

endmodule

// File: tb/tb_mc_updown_counter.sv
// Directed self-checking bench for mc_updown_counter (8-bit instance plus a 2x4-bit cascade).
// BCD expectations follow MC_COUNTER_BCD_EN so the bench matches whichever build it is compiled with.
module tb_mc_updown_counter;

  logic       clock = 1'b0;
  logic       reset, preset_enable, up_down, carry_in, one_shot, bcd_mode;
  logic [7:0] preset, result;
  logic       carry_out, wrapped;

  logic [3:0] lo_preset, hi_preset, lo_res, hi_res;
  logic       c_cin, lo_co, hi_co;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mc_updown_counter #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .preset_enable(preset_enable), .preset(preset),
    .up_down(up_down), .carry_in(carry_in), .one_shot(one_shot), .bcd_mode(bcd_mode),
    .result(result), .carry_out(carry_out), .wrapped(wrapped)
  );

  mc_updown_counter #(.WIDTH(4)) u_lo (
    .clock(clock), .reset(reset), .preset_enable(preset_enable), .preset(lo_preset),
    .up_down(up_down), .carry_in(c_cin), .one_shot(1'b0), .bcd_mode(1'b0),
    .result(lo_res), .carry_out(lo_co), .wrapped()
  );

  mc_updown_counter #(.WIDTH(4)) u_hi (
    .clock(clock), .reset(reset), .preset_enable(preset_enable), .preset(hi_preset),
    .up_down(up_down), .carry_in(lo_co), .one_shot(1'b0), .bcd_mode(1'b0),
    .result(hi_res), .carry_out(hi_co), .wrapped()
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    preset_enable = 1'b1;
    preset        = v;
    tick();
    preset_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; preset_enable = 1'b0; preset = '0; up_down = 1'b1;
    carry_in = 1'b1; one_shot = 1'b0; bcd_mode = 1'b0;
    lo_preset = '0; hi_preset = '0; c_cin = 1'b1;

    tick();
    check("rst_result", result, 8'h00);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_co_cin1", carry_out, 1'b1);
    carry_in = 1'b0; up_down = 1'b0; #1;
    check("rst_co_down", carry_out, 1'b0);
    reset = 1'b0; carry_in = 1'b1; up_down = 1'b1;

    load(8'hFE);
    check("load_fe", result, 8'hFE);
    carry_in = 1'b0;
    tick();
    check("up_ff", result, 8'hFF);
    check("up_ff_co", carry_out, 1'b0);
    check("up_ff_wr", wrapped, 1'b0);
    tick();
    check("wrap_up", result, 8'h00);
    check("wrap_up_wr", wrapped, 1'b1);
    check("wrap_up_co", carry_out, 1'b1);
    tick();
    check("sticky_res", result, 8'h01);
    check("sticky_wr", wrapped, 1'b1);

    carry_in = 1'b1;
    load(8'h00);
    check("load_clr_wr", wrapped, 1'b0);
    up_down = 1'b0; carry_in = 1'b0;
    tick();
    check("wrap_down", result, 8'hFF);
    check("wrap_down_wr", wrapped, 1'b1);

    carry_in = 1'b1;
    load(8'h33);
    tick();
    check("hold_cin1", result, 8'h33);

    load(8'h01);
    one_shot = 1'b1; carry_in = 1'b0;
    tick();
    tick();
    tick();
    check("os_hold", result, 8'h00);
    check("os_co", carry_out, 1'b0);
    check("os_wr", wrapped, 1'b0);
    up_down = 1'b1; #1;
    check("os_dir_co", carry_out, 1'b1);
    tick();
    check("os_release", result, 8'h01);
    one_shot = 1'b0;

    carry_in = 1'b1;
    load(8'hFF);
    carry_in = 1'b0;
    tick();
    check("pre_wr_set", wrapped, 1'b1);
    up_down = 1'b0;
    preset_enable = 1'b1; preset = 8'h55;
    tick();
    check("ld_vs_cnt", result, 8'h55);
    check("ld_vs_cnt_wr", wrapped, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_vs_ld", result, 8'h00);
    reset = 1'b0; preset_enable = 1'b0; carry_in = 1'b1;

    bcd_mode = 1'b1; up_down = 1'b1;
`ifdef MC_COUNTER_BCD_EN
    load(8'h09);
    carry_in = 1'b0;
    tick();
    check("bcd_09_up", result, 8'h10);
    carry_in = 1'b1;
    load(8'h99);
    carry_in = 1'b0; #1;
    check("bcd_99_co", carry_out, 1'b0);
    tick();
    check("bcd_wrap", result, 8'h00);
    check("bcd_wrap_wr", wrapped, 1'b1);
    carry_in = 1'b1;
    load(8'h10);
    up_down = 1'b0; carry_in = 1'b0;
    tick();
    check("bcd_10_dn", result, 8'h09);
    carry_in = 1'b1;
    load(8'h00);
    carry_in = 1'b0;
    tick();
    check("bcd_dn_wrap", result, 8'h99);
    carry_in = 1'b1;
    load(8'h0F);
    carry_in = 1'b0;
    tick();
    check("bcd_inv_dn", result, 8'h0E);
    carry_in = 1'b1; up_down = 1'b1;
    load(8'h0A);
    carry_in = 1'b0;
    tick();
    check("bcd_inv_up", result, 8'h10);
`else
    load(8'h09);
    carry_in = 1'b0;
    tick();
    check("nobcd_09_up", result, 8'h0A);
    carry_in = 1'b1;
    load(8'h99);
    carry_in = 1'b0; #1;
    check("nobcd_99_co", carry_out, 1'b1);
`endif
    bcd_mode = 1'b0; carry_in = 1'b1;

    up_down = 1'b1; lo_preset = 4'hF; hi_preset = 4'h0;
    load(8'h00);
    c_cin = 1'b0; #1;
    check("chain_lo_co", lo_co, 1'b0);
    tick();
    check("chain_val", {hi_res, lo_res}, 8'h10);
    check("chain_hi_co", hi_co, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
